// File: rtl/audio_pkg.sv
// Shared audio types for the voice/mixer/DAC path.
// Contents:
//   SAMPLE_W  - width of one PCM sample (16)
//   sample_t  - signed two's-complement PCM sample
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Sample hand-off between the mixer output and the I2S DAC transmitter.
// Signals:
//   sample_l, sample_r - stereo pair offered by the producer
//   sample_valid       - producer has a pair on sample_l/sample_r
//   sample_ready       - transmitter holding buffer is empty
// Modports:
//   master - producer side (mixer / testbench)
//   slave  - consumer side (i2s_dac_tx)
import audio_pkg::*;

interface i2s_dac_tx_if;

    sample_t sample_l;
    sample_t sample_r;
    logic    sample_valid;
    logic    sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/i2s_clk_gen.sv
// I2S bus-master timing: BCLK divider, slot bit counter and word select.
// Ports:
//   Clk, Reset   - system clock, synchronous active-low reset
//   AUD_BCLK     - bit clock, Clk/(2*BCLK_DIV)
//   AUD_DACLRCK  - word select, 0 = left slot, 1 = right slot
//   fall         - high in the cycle whose Clk edge drives BCLK 1->0
//   frame_start  - fall event on which bit_cnt wraps to 0
//   bit_cnt      - current bit position within the frame (pre-update value)
import audio_pkg::*;

module i2s_clk_gen #(
    parameter  int BCLK_DIV = 2,
    parameter  int CH_BITS  = 32,
    localparam int BIT_W    = $clog2(2 * CH_BITS)
) (
    input  logic             Clk,
    input  logic             Reset,
    output logic             AUD_BCLK,
    output logic             AUD_DACLRCK,
    output logic             fall,
    output logic             frame_start,
    output logic [BIT_W-1:0] bit_cnt
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * CH_BITS - 1);
    localparam logic [BIT_W-1:0] CH_START = BIT_W'(CH_BITS);

    logic [DIV_W-1:0] div_cnt_r;
    logic             bclk_r;
    logic             lrck_r;
    logic [BIT_W-1:0] bit_cnt_r;
    logic             terminal_s;
    logic             fall_s;
    logic [BIT_W-1:0] bit_nxt_s;

    // Divider terminal count, fall detection and next bit position.
    always_comb begin
        terminal_s = (div_cnt_r == DIV_LAST);
        fall_s     = terminal_s && bclk_r;
        if (bit_cnt_r == BIT_LAST) begin
            bit_nxt_s = {BIT_W{1'b0}};
        end else begin
            bit_nxt_s = bit_cnt_r + BIT_W'(1);
        end
    end

    // Divider, BCLK toggle, and bit counter / word select advanced on falls.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= 1'b0;
            lrck_r    <= 1'b0;
            bit_cnt_r <= BIT_LAST;
        end else if (terminal_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= ~bclk_r;
            if (bclk_r) begin
                bit_cnt_r <= bit_nxt_s;
                lrck_r    <= (bit_nxt_s >= CH_START);
            end else begin
                bit_cnt_r <= bit_cnt_r;
                lrck_r    <= lrck_r;
            end
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    assign AUD_BCLK    = bclk_r;
    assign AUD_DACLRCK = lrck_r;
    assign fall        = fall_s;
    assign frame_start = fall_s && (bit_cnt_r == BIT_LAST);
    assign bit_cnt     = bit_cnt_r;

endmodule

// File: rtl/i2s_dac_tx.sv
// Stereo 16-bit Philips I2S DAC transmitter (bus master).
// A one-entry holding buffer accepts sample pairs; each frame start loads the
// held pair into the left/right shift registers, or repeats the previously
// transmitted pair (and pulses underrun) when the buffer is empty.
// Ports:
//   Clk, Reset    - system clock, synchronous active-low reset
//   sample_if     - slave side of the sample valid/ready hand-off
//   AUD_BCLK      - bit clock to the codec
//   AUD_DACLRCK   - word select, 0 = left, 1 = right
//   AUD_DACDAT    - serial data, MSB first, one BCLK after LRCK changes
//   frame_pulse   - one-cycle pulse per frame start
//   underrun      - one-cycle pulse when a frame starts with an empty buffer
//   underrun_cnt  - saturating underrun count (only with
//                   I2S_DAC_TX_UNDERRUN_CNT_EN defined)
import audio_pkg::*;

module i2s_dac_tx #(
    parameter int BCLK_DIV = 2,
    parameter int CH_BITS  = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    i2s_dac_tx_if.slave       sample_if,
    output logic              AUD_BCLK,
    output logic              AUD_DACLRCK,
    output logic              AUD_DACDAT,
    output logic              frame_pulse,
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
    output logic              underrun,
    output logic [15:0]       underrun_cnt
`else
    output logic              underrun
`endif
);

    localparam int BIT_W = $clog2(2 * CH_BITS);
    localparam logic [BIT_W-1:0] LEFT_END  = BIT_W'(SAMPLE_W);
    localparam logic [BIT_W-1:0] RIGHT_BEG = BIT_W'(CH_BITS);
    localparam logic [BIT_W-1:0] RIGHT_END = BIT_W'(CH_BITS + SAMPLE_W);

    logic                fall_s;
    logic                frame_start_s;
    logic [BIT_W-1:0]    bit_cnt_s;
    logic                accept_s;
    logic                full_s;
    logic                left_win_s;
    logic                right_win_s;

    logic                ready_r;
    sample_t             hold_l_r;
    sample_t             hold_r_r;
    sample_t             last_l_r;
    sample_t             last_r_r;
    logic [SAMPLE_W-1:0] shift_l_r;
    logic [SAMPLE_W-1:0] shift_r_r;
    logic                dat_r;
    logic                frame_pulse_r;
    logic                underrun_r;

    i2s_clk_gen #(
        .BCLK_DIV (BCLK_DIV),
        .CH_BITS  (CH_BITS)
    ) u_clk_gen (
        .Clk         (Clk),
        .Reset       (Reset),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .fall        (fall_s),
        .frame_start (frame_start_s),
        .bit_cnt     (bit_cnt_s)
    );

    // Handshake and slot windows. bit_cnt is the value before the fall, so
    // new positions 1..16 correspond to current positions 0..15.
    always_comb begin
        full_s      = ~ready_r;
        accept_s    = sample_if.sample_valid && ready_r;
        left_win_s  = (bit_cnt_s < LEFT_END);
        right_win_s = (bit_cnt_s >= RIGHT_BEG) && (bit_cnt_s < RIGHT_END);
    end

    // Holding buffer: frame start drains it, otherwise an accept fills it.
    // An accept coinciding with an empty frame start is kept for the next frame.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ready_r  <= 1'b1;
            hold_l_r <= sample_t'(16'sh0000);
            hold_r_r <= sample_t'(16'sh0000);
        end else if (frame_start_s && full_s) begin
            ready_r  <= 1'b1;
        end else if (accept_s) begin
            ready_r  <= 1'b0;
            hold_l_r <= sample_if.sample_l;
            hold_r_r <= sample_if.sample_r;
        end else begin
            ready_r  <= ready_r;
        end
    end

    // Frame load / repeat, serial shift-out and status pulses.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            last_l_r      <= sample_t'(16'sh0000);
            last_r_r      <= sample_t'(16'sh0000);
            shift_l_r     <= 16'h0000;
            shift_r_r     <= 16'h0000;
            dat_r         <= 1'b0;
            frame_pulse_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else begin
            frame_pulse_r <= frame_start_s;
            underrun_r    <= frame_start_s && !full_s;
            if (frame_start_s) begin
                dat_r <= 1'b0;
                if (full_s) begin
                    shift_l_r <= hold_l_r;
                    shift_r_r <= hold_r_r;
                    last_l_r  <= hold_l_r;
                    last_r_r  <= hold_r_r;
                end else begin
                    shift_l_r <= last_l_r;
                    shift_r_r <= last_r_r;
                end
            end else if (fall_s) begin
                if (left_win_s) begin
                    dat_r     <= shift_l_r[SAMPLE_W-1];
                    shift_l_r <= {shift_l_r[SAMPLE_W-2:0], 1'b0};
                end else if (right_win_s) begin
                    dat_r     <= shift_r_r[SAMPLE_W-1];
                    shift_r_r <= {shift_r_r[SAMPLE_W-2:0], 1'b0};
                end else begin
                    dat_r     <= 1'b0;
                end
            end else begin
                dat_r <= dat_r;
            end
        end
    end

`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_r;

    // Saturating count of frames started with an empty buffer.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            underrun_cnt_r <= 16'h0000;
        end else if (frame_start_s && !full_s && (underrun_cnt_r != 16'hFFFF)) begin
            underrun_cnt_r <= underrun_cnt_r + 16'h0001;
        end else begin
            underrun_cnt_r <= underrun_cnt_r;
        end
    end

    assign underrun_cnt = underrun_cnt_r;
`endif

    assign sample_if.sample_ready = ready_r;
    assign AUD_DACDAT             = dat_r;
    assign frame_pulse            = frame_pulse_r;
    assign underrun               = underrun_r;

endmodule
